// File: rtl/axi4_lite_pkg.sv
// Shared types and constants for the AXI4-Lite write arbiter.
// Build option: AXI_WRITE_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
package axi4_lite_pkg;

  localparam int unsigned DefAddrWidth = 32;
  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned StrbWidth    = 4;

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/axi4_lite_rr_picker.sv
// Combinational winner select across NUM_REQ requesters.
// Round-robin from ptr_i by default; AXI_WRITE_ARB_FIXED_PRIO_EN picks the lowest index instead.
module axi4_lite_rr_picker #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         valid_i,
`ifndef AXI_WRITE_ARB_FIXED_PRIO_EN
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
`endif
  output logic                       any_valid_o,
  output logic [$clog2(NUM_REQ)-1:0] winner_o
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

`ifdef AXI_WRITE_ARB_FIXED_PRIO_EN
  always_comb begin
    any_valid_o = |valid_i;
    winner_o    = '0;
    // Descending scan so the lowest set index is the last assignment.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (valid_i[i]) winner_o = IdxW'(i);
    end
  end
`else
  int unsigned idx;
  logic        found;

  always_comb begin
    any_valid_o = |valid_i;
    winner_o    = '0;
    found       = 1'b0;
    idx         = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr_i) + i) % NUM_REQ;
      if (!found && valid_i[idx]) begin
        found    = 1'b1;
        winner_o = IdxW'(idx);
      end
    end
  end
`endif

endmodule

// File: rtl/axi4_lite_write_arbiter.sv
// Shares one AXI4-Lite write master between NUM_REQ requesters, one write outstanding at a time.
// Build option: AXI_WRITE_ARB_FIXED_PRIO_EN selects fixed priority (no rotating pointer).
module axi4_lite_write_arbiter
  import axi4_lite_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned DATA_WIDTH = DefDataWidth
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ*StrbWidth-1:0]    req_strobe,
  output logic [NUM_REQ-1:0]              req_grant,
  output logic [NUM_REQ-1:0]              req_done,
  output logic                            write_start,
  output logic [ADDR_WIDTH-1:0]           write_addr,
  output logic [DATA_WIDTH-1:0]           write_data,
  output logic [StrbWidth-1:0]            write_strobe,
  input  logic                            write_busy
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  arb_state_e            state_q, state_d;
  logic [IdxW-1:0]       win_q, win_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [StrbWidth-1:0]  strb_q, strb_d;
  logic [IdxW-1:0]       pick_idx;
  logic                  any_valid;
  logic                  grant_fire;
  logic                  done_fire;

`ifndef AXI_WRITE_ARB_FIXED_PRIO_EN
  logic [IdxW-1:0] ptr_q, ptr_d;
`endif

  axi4_lite_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .valid_i     (req_valid),
`ifndef AXI_WRITE_ARB_FIXED_PRIO_EN
    .ptr_i       (ptr_q),
`endif
    .any_valid_o (any_valid),
    .winner_o    (pick_idx)
  );

  // Gated by rst so nothing pulses while reset is being applied.
  assign grant_fire = rst && (state_q == ST_ARB) && any_valid && !write_busy;
  assign done_fire  = rst && (state_q == ST_WAIT) && !write_busy;

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    addr_d  = addr_q;
    data_d  = data_q;
    strb_d  = strb_q;
`ifndef AXI_WRITE_ARB_FIXED_PRIO_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      ST_ARB: begin
        if (grant_fire) begin
          win_d   = pick_idx;
          addr_d  = req_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
          data_d  = req_data[pick_idx*DATA_WIDTH +: DATA_WIDTH];
          strb_d  = req_strobe[pick_idx*StrbWidth +: StrbWidth];
`ifndef AXI_WRITE_ARB_FIXED_PRIO_EN
          ptr_d   = (pick_idx == IdxW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
`endif
          state_d = ST_START;
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT:  if (!write_busy) state_d = ST_ARB;
      default:  state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_ARB;
      win_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
`ifndef AXI_WRITE_ARB_FIXED_PRIO_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
`ifndef AXI_WRITE_ARB_FIXED_PRIO_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_grant[i] = grant_fire && (pick_idx == IdxW'(i));
      req_done[i]  = done_fire && (win_q == IdxW'(i));
    end
  end

  assign write_start  = (state_q == ST_START);
  assign write_addr   = write_start ? addr_q : '0;
  assign write_data   = write_start ? data_q : '0;
  assign write_strobe = write_start ? strb_q : '0;

endmodule

// File: tb/tb_axi4_lite_write_arbiter.sv
// Directed bench for axi4_lite_write_arbiter with a small busy-counter model of the write master.
module tb_axi4_lite_write_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Two-requester instance
  logic [1:0]  v2 = '0;
  logic [63:0] a2 = '0, d2 = '0;
  logic [7:0]  s2 = '0;
  logic [1:0]  g2, dn2;
  logic        ws2, busy2;
  logic [31:0] wa2, wd2;
  logic [3:0]  wst2;
  int          len2 = 2;
  int          cnt2 = 0;

  // Three-requester instance
  logic [2:0]  v3 = '0;
  logic [95:0] a3 = '0, d3 = '0;
  logic [11:0] s3 = '0;
  logic [2:0]  g3, dn3;
  logic        ws3, busy3;
  logic [31:0] wa3, wd3;
  logic [3:0]  wst3;
  int          cnt3 = 0;

  int n_checks = 0;
  int n_fail   = 0;

  axi4_lite_write_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut2 (
    .clk (clk), .rst (rst), .req_valid (v2), .req_addr (a2), .req_data (d2),
    .req_strobe (s2), .req_grant (g2), .req_done (dn2), .write_start (ws2),
    .write_addr (wa2), .write_data (wd2), .write_strobe (wst2), .write_busy (busy2)
  );

  axi4_lite_write_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut3 (
    .clk (clk), .rst (rst), .req_valid (v3), .req_addr (a3), .req_data (d3),
    .req_strobe (s3), .req_grant (g3), .req_done (dn3), .write_start (ws3),
    .write_addr (wa3), .write_data (wd3), .write_strobe (wst3), .write_busy (busy3)
  );

  // Master model: busy for len cycles starting the cycle after write_start.
  always @(posedge clk) begin
    if (!rst) cnt2 <= 0;
    else if (ws2) cnt2 <= len2;
    else if (cnt2 != 0) cnt2 <= cnt2 - 1;
  end
  always @(posedge clk) begin
    if (!rst) cnt3 <= 0;
    else if (ws3) cnt3 <= 2;
    else if (cnt3 != 0) cnt3 <= cnt3 - 1;
  end
  assign busy2 = (cnt2 != 0);
  assign busy3 = (cnt3 != 0);

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [1:0]  gval2 [4];
  int          gcyc2 [4];
  logic [2:0]  gval3 [2];
  logic [31:0] saddr3 [2];
  logic [1:0]  exp2 [4];
  logic [2:0]  exp3 [2];
  logic [31:0] expa3 [2];
  int          ng, nd, ns, extra;
  logic [2:0]  done3_seen;

  initial begin
`ifdef AXI_WRITE_ARB_FIXED_PRIO_EN
    exp2  = '{2'b01, 2'b01, 2'b01, 2'b01};
    exp3  = '{3'b001, 3'b001};
    expa3 = '{32'h3000_0000, 32'h3000_0000};
`else
    exp2  = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp3  = '{3'b100, 3'b001};
    expa3 = '{32'h3000_0020, 32'h3000_0000};
`endif

    // Reset: request pending while held in reset must not be granted
    @(negedge clk); v2 = 2'b01; #1;
    check_eq("rst_grant_gated", 64'(g2), 64'(2'b00));
    @(negedge clk); v2 = 2'b00; #1;
    check_eq("rst_grant", 64'(g2), 0);
    check_eq("rst_done", 64'(dn2), 0);
    check_eq("rst_start", 64'(ws2), 0);
    check_eq("rst_addr", 64'(wa2), 0);
    check_eq("rst_data", 64'(wd2), 0);
    check_eq("rst_strobe", 64'(wst2), 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    // Single write from requester 0, slave always ready
    @(negedge clk);
    v2 = 2'b01; a2[31:0] = 32'h1000_0004; d2[31:0] = 32'hDEAD_BEEF; s2[3:0] = 4'hF; #1;
    check_eq("t1_grant_T", 64'(g2), 64'(2'b01));
    check_eq("t1_start_T", 64'(ws2), 0);
    @(negedge clk); v2 = 2'b00; #1;
    check_eq("t1_start_T1", 64'(ws2), 1);
    check_eq("t1_addr_T1", 64'(wa2), 64'h1000_0004);
    check_eq("t1_data_T1", 64'(wd2), 64'hDEAD_BEEF);
    check_eq("t1_strobe_T1", 64'(wst2), 64'hF);
    check_eq("t1_grant_T1", 64'(g2), 0);
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk); #1;
      check_eq($sformatf("t1_done_T%0d", k), 64'(dn2), (k == 4) ? 64'(2'b01) : 64'd0);
      check_eq($sformatf("t1_start_T%0d", k), 64'(ws2), 0);
    end
    check_eq("t1_addr_idle", 64'(wa2), 0);

    // Slave stall: 3 AW cycles + 2 B cycles on requester 1
    @(negedge clk);
    len2 = 7; v2 = 2'b10; a2[63:32] = 32'h2000_0010; d2[63:32] = 32'h1234_5678; s2[7:4] = 4'h3;
    #1;
    check_eq("st_grant_T", 64'(g2), 64'(2'b10));
    @(negedge clk); v2 = 2'b00; #1;
    check_eq("st_start_T1", 64'(ws2), 1);
    check_eq("st_addr_T1", 64'(wa2), 64'h2000_0010);
    check_eq("st_data_T1", 64'(wd2), 64'h1234_5678);
    check_eq("st_strobe_T1", 64'(wst2), 64'h3);
    for (int k = 2; k <= 9; k++) begin
      @(negedge clk); #1;
      check_eq($sformatf("st_done_T%0d", k), 64'(dn2), (k == 9) ? 64'(2'b10) : 64'd0);
      check_eq($sformatf("st_start_T%0d", k), 64'(ws2), 0);
    end
    @(negedge clk); len2 = 2;

    // Contention: both requesters valid for four writes
    ng = 0; nd = 0; extra = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk); v2 = (ng < 4) ? 2'b11 : 2'b00; #1;
      if (g2 != 2'b00) begin
        if (ng < 4) begin
          gval2[ng] = g2; gcyc2[ng] = c; ng++;
        end else extra++;
      end
      if (dn2 != 2'b00) nd++;
      if (ng == 4 && nd == 4) break;
    end
    v2 = 2'b00;
    check_eq("ct_grants", 64'(ng), 4);
    check_eq("ct_dones", 64'(nd), 4);
    check_eq("ct_extra", 64'(extra), 0);
    for (int k = 0; k < 4; k++) begin
      if (k < ng) check_eq($sformatf("ct_order%0d", k), 64'(gval2[k]), 64'(exp2[k]));
      if (k > 0 && k < ng) check_eq($sformatf("ct_gap%0d", k), 64'(gcyc2[k] - gcyc2[k-1]), 5);
    end

    // Wrap-around on the 3-requester instance: push ptr to 2 first
    a3 = {32'h3000_0020, 32'h3000_0010, 32'h3000_0000};
    d3 = {32'hC2, 32'hC1, 32'hC0};
    s3 = 12'hF_F_F;
    @(negedge clk); v3 = 3'b010; #1;
    check_eq("wr_grant1", 64'(g3), 64'(3'b010));
    done3_seen = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); v3 = 3'b000; #1;
      if (dn3 != 3'b000) begin
        done3_seen = dn3;
        break;
      end
    end
    check_eq("wr_done1", 64'(done3_seen), 64'(3'b010));
    ng = 0; ns = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); v3 = (ng < 2) ? 3'b101 : 3'b000; #1;
      if (g3 != 3'b000 && ng < 2) begin
        gval3[ng] = g3; ng++;
      end
      if (ws3 && ns < 2) begin
        saddr3[ns] = wa3; ns++;
      end
      if (ng == 2 && ns == 2 && dn3 != 3'b000) break;
    end
    v3 = 3'b000;
    check_eq("wr_ngrant", 64'(ng), 2);
    for (int k = 0; k < 2; k++) begin
      if (k < ng) check_eq($sformatf("wr_order%0d", k), 64'(gval3[k]), 64'(exp3[k]));
      if (k < ns) check_eq($sformatf("wr_addr%0d", k), 64'(saddr3[k]), 64'(expa3[k]));
    end
    repeat (4) @(negedge clk);

    // Reset during ST_WAIT: no done, outputs cleared, ptr back to 0
    @(negedge clk);
    len2 = 7; v2 = 2'b01; d2[31:0] = 32'hCAFE_0001; #1;
    check_eq("rm_grant", 64'(g2), 64'(2'b01));
    @(negedge clk); v2 = 2'b00; #1;
    check_eq("rm_start", 64'(ws2), 1);
    @(negedge clk);
    @(negedge clk); rst = 1'b0; v2 = 2'b11; #1;
    @(negedge clk); #1;
    check_eq("rm_grant_in_rst", 64'(g2), 0);
    check_eq("rm_done_in_rst", 64'(dn2), 0);
    check_eq("rm_start_in_rst", 64'(ws2), 0);
    check_eq("rm_addr_in_rst", 64'(wa2), 0);
    check_eq("rm_data_in_rst", 64'(wd2), 0);
    check_eq("rm_strobe_in_rst", 64'(wst2), 0);
    @(negedge clk); rst = 1'b1; v2 = 2'b00; len2 = 2; nd = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      if (dn2 != 2'b00) nd++;
    end
    check_eq("rm_no_done", 64'(nd), 0);
    @(negedge clk); v2 = 2'b11; d2[31:0] = 32'h0BAD_F00D; #1;
    check_eq("rm_fresh_grant", 64'(g2), 64'(2'b01));
    @(negedge clk); v2 = 2'b00; #1;
    check_eq("rm_fresh_data", 64'(wd2), 64'h0BAD_F00D);
    repeat (3) @(negedge clk);
    #1;
    check_eq("rm_fresh_done", 64'(dn2), 64'(2'b01));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
